// File: rtl/pipelined_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_shifter
//
// Pipelined logarithmic barrel shifter (SLL / SRL / SRA, optional ROR).
// It sits between the ALU operand mux and writeback. Both sides use a
// valid/ready handshake, and backpressure is applied all the way back.
//
// The log2(N) shift levels are spread over STAGES register stages. Level i
// is evaluated in stage floor(i*STAGES/LOG2N). Each stage is combinational
// shift logic followed by a register. That register holds valid, the partial
// result, shamt, op, the operand sign bit and the user tag.
//
// Optional feature macro: PIPELINED_SHIFTER_ROTATE_EN
//   defined   : op 2'b11 is rotate-right
//   undefined : op 2'b11 decodes as SRL, and no rotate logic is built
//
// Parameters:
//   N      - data width, a power of two >= 2
//   STAGES - number of pipeline register stages, 1..log2(N)
//   TAG_W  - width of the sideband tag
//
// Ports:
//   clk       - clock; all state changes on its rising edge
//   rst       - asynchronous reset, active low
//   in_valid  - an operation is presented
//   in_ready  - the operation is accepted this cycle
//   in_data   - operand
//   in_shamt  - shift amount, 0..N-1
//   in_op     - 00 SLL, 01 SRL, 10 SRA, 11 ROR (or SRL)
//   in_tag    - sideband tag, returned unchanged with the result
//   out_valid - a result is presented
//   out_ready - the consumer takes the result this cycle
//   out_data  - shifted result
//   out_tag   - tag belonging to out_data
// ---------------------------------------------------------------------------
module pipelined_shifter #(
  parameter int  N      = 32,
  parameter int  STAGES = 1,
  parameter int  TAG_W  = 4,
  localparam int LOG2N  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [LOG2N-1:0] in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag
);

  // Index of the stage that evaluates shift level lvl.
  function automatic int stage_of(input int lvl);
    return (lvl * STAGES) / LOG2N;
  endfunction

  // One level of the logarithmic shifter: shift by 2^lvl.
  // For SRA the fill comes from the original operand's MSB (sign). That bit
  // is carried alongside the data, so the fill does not depend on the
  // partially shifted value.
  function automatic logic [N-1:0] shift_level(input logic [N-1:0] d,
                                               input int          lvl,
                                               input logic [1:0]  op,
                                               input logic        sign);
    int           amt;
    logic [N-1:0] fill;
    logic [N-1:0] res;
    amt  = 1 << lvl;
    fill = ~({N{1'b1}} >> amt);  // top amt bits set
    case (op)
      2'b00:   res = d << amt;
      2'b10:   res = (d >> amt) | (sign ? fill : '0);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
      2'b11:   res = (d >> amt) | (d << (N - amt));
`endif
      default: res = d >> amt;  // SRL, and op 11 when rotate is disabled
    endcase
    return res;
  endfunction

  genvar gi;

  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    // Source of this stage: either the block inputs or the previous register.
    logic             src_valid;
    logic [N-1:0]     src_data;
    logic [LOG2N-1:0] src_shamt;
    logic [1:0]       src_op;
    logic             src_sign;
    logic [TAG_W-1:0] src_tag;

    logic             down_ready;  // downstream takes this stage's contents
    logic             load;        // this stage register loads this cycle

    logic             valid_reg;
    logic [N-1:0]     data_reg;
    logic [LOG2N-1:0] shamt_reg;
    logic [1:0]       op_reg;
    logic             sign_reg;
    logic [TAG_W-1:0] tag_reg;

    logic [N-1:0]     data_next;

    if (gi == 0) begin : g_src_in
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign src_shamt = in_shamt;
      assign src_op    = in_op;
      assign src_sign  = in_data[N-1];
      assign src_tag   = in_tag;
    end else begin : g_src_prev
      assign src_valid = g_stage[gi-1].valid_reg;
      assign src_data  = g_stage[gi-1].data_reg;
      assign src_shamt = g_stage[gi-1].shamt_reg;
      assign src_op    = g_stage[gi-1].op_reg;
      assign src_sign  = g_stage[gi-1].sign_reg;
      assign src_tag   = g_stage[gi-1].tag_reg;
    end

    if (gi == STAGES - 1) begin : g_down_out
      assign down_ready = out_ready;
    end else begin : g_down_next
      assign down_ready = g_stage[gi+1].load;
    end

    // An empty stage always loads, which collapses bubbles whenever upstream
    // data is waiting.
    assign load = !valid_reg || down_ready;

    // Apply only the levels that belong to this stage. The full shamt is
    // carried along, and each stage looks only at its own bits.
    always_comb begin
      data_next = src_data;
      for (int i = 0; i < LOG2N; i++) begin
        if (stage_of(i) == gi && src_shamt[i]) begin
          data_next = shift_level(data_next, i, src_op, src_sign);
        end
      end
    end

    // The payload is written only with a valid source. Bubbles and idle
    // inputs (possibly X) therefore never disturb the held data.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
        shamt_reg <= '0;
        op_reg    <= '0;
        sign_reg  <= 1'b0;
        tag_reg   <= '0;
      end else if (load) begin
        valid_reg <= src_valid;
        if (src_valid) begin
          data_reg  <= data_next;
          shamt_reg <= src_shamt;
          op_reg    <= src_op;
          sign_reg  <= src_sign;
          tag_reg   <= src_tag;
        end
      end
    end
  end

  // in_ready is held low while reset is asserted.
  assign in_ready  = rst && g_stage[0].load;
  assign out_valid = g_stage[STAGES-1].valid_reg;
  assign out_data  = g_stage[STAGES-1].data_reg;
  assign out_tag   = g_stage[STAGES-1].tag_reg;

endmodule

// File: tb/tb_pipelined_shifter.sv
module tb_pipelined_shifter;
  localparam int N  = 32;
  localparam int ST = 5;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  // STAGES = 5 instance
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  in_data, out_data;
  logic [4:0]    in_shamt;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag, out_tag;
  // STAGES = 1 instance
  logic          in_valid1, in_ready1, out_valid1, out_ready1;
  logic [N-1:0]  in_data1, out_data1;
  logic [4:0]    in_shamt1;
  logic [1:0]    in_op1;
  logic [TW-1:0] in_tag1, out_tag1;

  pipelined_shifter #(.N(N), .STAGES(ST), .TAG_W(TW)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag)
  );

  pipelined_shifter #(.N(N), .STAGES(1), .TAG_W(TW)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .in_shamt(in_shamt1), .in_op(in_op1), .in_tag(in_tag1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_tag(out_tag1)
  );

  typedef struct packed {
    logic [N-1:0]  data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   out_count = 0;
  int   in_count  = 0;
  int   rst_epoch = 0;   // bumped by the stimulus on every reset pulse
  int   mon_epoch = 0;
  bit   rand_mode = 1'b0;
  logic          hold_prev = 1'b0;
  logic [N-1:0]  hold_data = '0;
  logic [TW-1:0] hold_tag  = '0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  // Reference model: direct whole-amount shifts.
  function automatic logic [N-1:0] model(input logic [N-1:0] d, input logic [4:0] sh,
                                         input logic [1:0] op);
    logic [N-1:0] r;
    case (op)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = $signed(d) >>> sh;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
      default: r = (d >> sh) | (d << (32 - int'(sh)));
`else
      default: r = d >> sh;
`endif
    endcase
    return r;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (in_valid && in_ready) begin
        sb.push_back('{data: model(in_data, in_shamt, in_op), tag: in_tag});
        in_count <= in_count + 1;
      end
      if (hold_prev && mon_epoch == rst_epoch) begin
        check("stable_valid", 32'(out_valid), 32'd1);
        check("stable_data", out_data, hold_data);
        check("stable_tag", 32'(out_tag), 32'(hold_tag));
      end
      if (out_valid && out_ready) begin
        n_checks++;
        assert (sb.size() > 0)
        else begin
          n_fail++;
          $error("FAIL unexpected_output: observed data 0x%08h tag %0d expected no result",
                 out_data, out_tag);
        end
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("result_data", out_data, mon_e.data);
          check("result_tag", 32'(out_tag), 32'(mon_e.tag));
          out_count <= out_count + 1;
        end
      end
      hold_prev <= out_valid && !out_ready;
      hold_data <= out_data;
      hold_tag  <= out_tag;
    end else begin
      hold_prev <= 1'b0;
    end
    mon_epoch <= rst_epoch;
  end

  task automatic send_op(input logic [N-1:0] d, input logic [4:0] sh,
                         input logic [1:0] op, input logic [TW-1:0] tag);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    in_tag   = tag;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  // Idle cycle with garbage on the data inputs.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      in_shamt = 5'($urandom_range(0, 31));
      in_op    = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Requires an empty pipeline and out_ready high, called right after send_op.
  task automatic expect_after(input string name, input int lat,
                              input logic [N-1:0] d, input logic [TW-1:0] tag);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      check({name, "_early"}, 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, out_data, d);
    check({name, "_tag"}, 32'(out_tag), 32'(tag));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [N-1:0] ror_exp;
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; in_shamt1 = '0; in_op1 = '0; in_tag1 = '0;
    out_ready1 = 1'b1;

    // Reset state
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // STAGES=1: SRL 0x8000_0000 by 31, tag 3
    in_valid1 = 1'b1; in_data1 = 32'h8000_0000; in_shamt1 = 5'd31; in_op1 = 2'b01; in_tag1 = 4'd3;
    @(negedge clk);
    check("s1_in_ready", 32'(in_ready1), 32'd1);
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    @(negedge clk);
    check("s1_out_valid", 32'(out_valid1), 32'd1);
    check("s1_out_data", out_data1, 32'h0000_0001);
    check("s1_out_tag", 32'(out_tag1), 32'd3);
    @(negedge clk);
    check("s1_drained", 32'(out_valid1), 32'd0);
    @(posedge clk);
    #1;

    // STAGES=5: SRA then SLL on the next cycle
    send_op(32'hF000_0000, 5'd4, 2'b10, 4'd1);
    send_op(32'h0000_00FF, 5'd8, 2'b00, 4'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("sra_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check("sra_valid", 32'(out_valid), 32'd1);
    check("sra_data", out_data, 32'hFF00_0000);
    @(negedge clk);
    check("sll_valid", 32'(out_valid), 32'd1);
    check("sll_data", out_data, 32'h0000_FF00);
    @(posedge clk);
    #1;
    idle(2);

    // Op 11 by 1
`ifdef PIPELINED_SHIFTER_ROTATE_EN
    ror_exp = 32'h8000_0000;
`else
    ror_exp = 32'h0000_0000;
`endif
    send_op(32'h0000_0001, 5'd1, 2'b11, 4'd5);
    expect_after("op11", ST, ror_exp, 4'd5);
    @(posedge clk);
    #1;

    // shamt boundaries for every op (checked by the scoreboard)
    for (int op = 0; op < 4; op++) begin
      send_op(32'h8000_0001, 5'd31, 2'(op), 4'(op));
      send_op(32'hA5A5_5A5A, 5'd0, 2'(op), 4'(op + 4));
      send_op(32'h7FFF_FFFE, 5'd31, 2'(op), 4'(op + 8));
    end
    idle(8);

    // Backpressure: 8 ops with out_ready low
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_op($urandom, 5'($urandom_range(0, 31)), 2'(i % 4), 4'(i));
    in_valid = 1'b1; in_data = 32'h1234_5678; in_shamt = 5'd3; in_op = 2'b10; in_tag = 4'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    c0 = out_count;
    send_op(32'h1234_5678, 5'd3, 2'b10, 4'd5);
    send_op($urandom, 5'($urandom_range(0, 31)), 2'b01, 4'd6);
    send_op($urandom, 5'($urandom_range(0, 31)), 2'b00, 4'd7);
    repeat (5) @(negedge clk);
    #1;
    check("drain_count", 32'(out_count - c0), 32'd8);
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset with 3 ops in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_op($urandom, 5'($urandom_range(0, 31)), 2'b01, 4'(i + 10));
    repeat (4) @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b0;
    sb.delete();
    rst_epoch++;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send_op(32'hF0F0_0000, 5'd16, 2'b10, 4'd9);
    expect_after("post_rst", ST, 32'hFFFF_F0F0, 4'd9);
    @(posedge clk);
    #1;

    // Random: 1000 ops with random out_ready and idle gaps
    c0 = out_count;
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_op($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'(i));
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    #1;
    check("random_empty", 32'(sb.size()), 32'd0);
    check("random_count", 32'(out_count - c0), 32'd1000);
    check("total_in_out", 32'(out_count), 32'(in_count - 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
